mem_stage_sram_like: RTL and testbench
======================================

# mem_stage_sram_like

Parametrised memory-access pipeline stage for a core using a split request/response data-SRAM interface. It holds one instruction between EX and WB and waits for the data response of a load or store. It extracts and extends load data for XLEN = 32 or 64, buffers early responses while WB stalls, and discards responses belonging to instructions killed by a flush. It also drives the MEM-stage forwarding bus.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64.
- MAX_DISCARD, 3, maximum number of in-flight responses to drop after a flush; counter width is clog2(MAX_DISCARD+1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  EX presents an instruction.
- ex_req  in  1  the instruction issued a data request that was accepted (addr_ok) in EX.
- ex_ld_op  in  3  load operation: 0 none, 1 lb, 2 lbu, 3 lh, 4 lhu, 5 lw, 6 lwu, 7 ld. Codes 6 and 7 are legal only when XLEN=64.
- ex_addr_lo  in  log2(XLEN/8)  low address bits.
- ex_result  in  XLEN  ALU/address result.
- ex_rf_we  in  1  register write enable.
- ex_rf_waddr  in  5  destination register.
- ex_pc  in  32  PC.
- ex_exc  in  1  exception already flagged upstream; ex_req is 0 whenever this is 1.
- mem_allow_in  out  1  stage can accept an instruction this cycle.
- data_ok  in  1  data response valid. Responses return in request order.
- rdata  in  XLEN  response data.
- flush  in  1  kill the stage contents (exception or ertn from WB).
- wb_allow_in  in  1  WB accepts this cycle.
- mem_valid  out  1  stage output valid to WB.
- mem_result  out  XLEN  final result.
- mem_rf_we, mem_rf_waddr, mem_pc, mem_exc  out  1/5/32/1  registered copies of the corresponding EX inputs.
- fwd_we  out  1  mem_valid & mem_rf_we.
- fwd_stall  out  1  load in the stage whose data is not yet available.
- req_block  out  1  discard counter full; EX must not issue a request.

## Operation
- State: stage registers; `waiting`; `buf_valid` with `rdata_buf` (XLEN); `discard_cnt`.
- `ready_go` = !req_r | buf_valid | (data_ok & discard_cnt==0).
- `mem_valid` = valid_r & ready_go.
- mem_allow_in = !valid_r | (ready_go & wb_allow_in), forced to 0 when flush=1.
- Capture: when ex_valid & mem_allow_in, all ex_* fields load and valid_r←1. Otherwise, when the stage advances (mem_valid & wb_allow_in), valid_r←0.
- Response attribution, in priority order:
  - discard_cnt>0: the response is dropped and the counter decrements.
  - Otherwise, if valid_r & req_r & !buf_valid: the response belongs to the current instruction.
  - Any other data_ok is a protocol error; the bench asserts on it.
- Buffering: a response attributed to the current instruction while wb_allow_in=0 is stored in rdata_buf and sets buf_valid. buf_valid clears when the stage advances or on flush.
- Load data: sel = buf_valid ? rdata_buf : rdata.
  - Shift sel right by ex_addr_lo×8.
  - Take the low 8 bits for lb/lbu, 16 for lh/lhu, 32 for lw/lwu, 64 for ld.
  - Sign-extend lb/lh/lw/ld; zero-extend lbu/lhu/lwu.
  - For XLEN=32, lw takes the full word.
- mem_result = (ld_op≠0) ? extracted data : ex_result.
- Flush: valid_r←0 and buf_valid←0.
  - discard_cnt += (valid_r & req_r & !buf_valid & !(data_ok & discard_cnt==0)).
  - discard_cnt −= (data_ok & discard_cnt>0).
  - Both the increment and the decrement may apply in the same cycle.
- fwd_stall = valid_r & (ld_op≠0) & !ready_go.
- req_block = (discard_cnt == MAX_DISCARD).

## Timing
- Reset (synchronous) clears valid_r, buf_valid and discard_cnt. All outputs are 0 except mem_allow_in=1.
- Non-memory instruction: latency one cycle, EX capture to mem_valid in the next cycle.
- Load/store: mem_valid is combinational on data_ok in the cycle it arrives. Earliest is the cycle after capture.
- Back-to-back throughput: one instruction per cycle when data_ok arrives each cycle and wb_allow_in=1.
- Buffered data is presented from rdata_buf in every later cycle until WB accepts.
- Stage outputs are stable while mem_valid & !wb_allow_in.

## Test plan
- ALU op with ex_result=0x1234_5678 and wb_allow_in=1 → mem_valid=1 one cycle after capture, mem_result=0x1234_5678.
- XLEN=32: lb, addr_lo=3, rdata=0x80FF_0000, data_ok two cycles after capture → mem_valid only in the data_ok cycle, result 0xFFFF_FF80. The same case with lbu → 0x0000_0080.
- data_ok arrives while wb_allow_in=0 for 3 cycles, rdata=0xDEAD_BEEF (lw) → buf_valid=1, mem_valid held with result 0xDEAD_BEEF, fwd_stall=0, clears when accepted.
- Flush while a load waits without data → discard_cnt=1. The next data_ok is dropped and discard_cnt returns to 0. A new load captured afterwards receives the following data_ok.
- Flush coincides with data_ok for the waiting load → discard_cnt stays 0 and the stage empties.
- XLEN=64: lwu at addr_lo=4, rdata=0x9000_0001_xxxx_xxxx → 0x0000_0000_9000_0001. lw at the same address → 0xFFFF_FFFF_9000_0001. Also: MAX_DISCARD flushes with no responses → req_block=1.

Source files
------------

// File: rtl/mem_stage_sram_like_if.sv
// ----------------------------------------------------------------------------
// mem_stage_sram_like_if
//
// Purpose: groups the EX-side instruction bus, the data-SRAM response channel,
// the WB handshake and the forwarding bus of the memory-access stage into one
// interface. Clock and reset are kept as plain ports on the stage itself.
//
// Signal summary:
//   EX -> MEM  : ex_valid, ex_req, ex_ld_op, ex_addr_lo, ex_result, ex_rf_we,
//                ex_rf_waddr, ex_pc, ex_exc
//   MEM -> EX  : mem_allow_in, req_block
//   SRAM -> MEM: data_ok, rdata
//   WB -> MEM  : flush, wb_allow_in
//   MEM -> WB  : mem_valid, mem_result, mem_rf_we, mem_rf_waddr, mem_pc, mem_exc
//   Forwarding : fwd_we, fwd_stall
//
// Modports:
//   master - the surrounding pipeline (drives EX, SRAM and WB side inputs)
//   slave  - the memory stage
// ----------------------------------------------------------------------------
interface mem_stage_sram_like_if #(
    parameter int XLEN = 32
);
    localparam int AW = $clog2(XLEN / 8);

    logic            ex_valid;
    logic            ex_req;
    logic [2:0]      ex_ld_op;
    logic [AW-1:0]   ex_addr_lo;
    logic [XLEN-1:0] ex_result;
    logic            ex_rf_we;
    logic [4:0]      ex_rf_waddr;
    logic [31:0]     ex_pc;
    logic            ex_exc;
    logic            mem_allow_in;

    logic            data_ok;
    logic [XLEN-1:0] rdata;

    logic            flush;
    logic            wb_allow_in;

    logic            mem_valid;
    logic [XLEN-1:0] mem_result;
    logic            mem_rf_we;
    logic [4:0]      mem_rf_waddr;
    logic [31:0]     mem_pc;
    logic            mem_exc;

    logic            fwd_we;
    logic            fwd_stall;
    logic            req_block;

    modport master (
        output ex_valid, ex_req, ex_ld_op, ex_addr_lo, ex_result, ex_rf_we,
               ex_rf_waddr, ex_pc, ex_exc, data_ok, rdata, flush, wb_allow_in,
        input  mem_allow_in, mem_valid, mem_result, mem_rf_we, mem_rf_waddr,
               mem_pc, mem_exc, fwd_we, fwd_stall, req_block
    );

    modport slave (
        input  ex_valid, ex_req, ex_ld_op, ex_addr_lo, ex_result, ex_rf_we,
               ex_rf_waddr, ex_pc, ex_exc, data_ok, rdata, flush, wb_allow_in,
        output mem_allow_in, mem_valid, mem_result, mem_rf_we, mem_rf_waddr,
               mem_pc, mem_exc, fwd_we, fwd_stall, req_block
    );
endinterface

// File: rtl/mem_stage_sram_like.sv
// ----------------------------------------------------------------------------
// mem_stage_sram_like
//
// Purpose: memory-access pipeline stage sitting between EX and WB for a core
// with a split request/response data SRAM. It holds one instruction, waits for
// the in-order data response of its load/store, extracts and extends load
// data (XLEN 32 or 64), parks an early response while WB stalls, and silently
// drops responses that belong to instructions killed by a flush.
//
// Ports:
//   clk    - clock
//   reset  - synchronous, active-high
//   bus    - mem_stage_sram_like_if.slave (EX inputs, SRAM response, WB
//            handshake, stage outputs, forwarding bus, req_block)
//
// Parameters:
//   XLEN        - datapath width, 32 or 64
//   MAX_DISCARD - maximum number of orphaned responses that may be in flight
// ----------------------------------------------------------------------------
module mem_stage_sram_like #(
    parameter int XLEN        = 32,
    parameter int MAX_DISCARD = 3
) (
    input logic                  clk,
    input logic                  reset,
    mem_stage_sram_like_if.slave bus
);
    localparam int AW = $clog2(XLEN / 8);
    localparam int CW = $clog2(MAX_DISCARD + 1);

    logic            r_valid;
    logic            r_req;
    logic [2:0]      r_ldOp;
    logic [AW-1:0]   r_addrLo;
    logic [XLEN-1:0] r_result;
    logic            r_rfWe;
    logic [4:0]      r_rfWaddr;
    logic [31:0]     r_pc;
    logic            r_exc;
    logic            r_bufValid;
    logic [XLEN-1:0] r_rdataBuf;
    logic [CW-1:0]   r_discardCnt;

    logic            w_discarding;
    logic            w_readyGo;
    logic            w_memValid;
    logic            w_allowIn;
    logic            w_advance;
    logic            w_rspMine;
    logic            w_killWaiting;
    logic            w_dropRsp;
    logic [XLEN-1:0] w_loadSel;
    logic [XLEN-1:0] w_loadShift;
    logic [XLEN-1:0] w_loadData;

    // While orphaned responses are outstanding, every data_ok belongs to one
    // of them, so nothing arriving can satisfy the current instruction. The
    // "waiting" condition of the stage is r_req & !r_bufValid.
    assign w_discarding  = (r_discardCnt != '0);
    assign w_readyGo     = !r_req || r_bufValid || (bus.data_ok && !w_discarding);
    assign w_memValid    = r_valid && w_readyGo;
    assign w_allowIn     = !bus.flush && (!r_valid || (w_readyGo && bus.wb_allow_in));
    assign w_advance     = w_memValid && bus.wb_allow_in;
    assign w_rspMine     = bus.data_ok && !w_discarding && r_valid && r_req && !r_bufValid;

    // A flush that kills an instruction still waiting for its data leaves
    // that response in flight; count it unless it is arriving right now.
    assign w_killWaiting = bus.flush && r_valid && r_req && !r_bufValid &&
                           !(bus.data_ok && !w_discarding);
    assign w_dropRsp     = bus.data_ok && w_discarding;

    // Load data comes from the parking buffer once WB has stalled a response,
    // otherwise straight from the SRAM in the cycle it returns.
    assign w_loadSel   = r_bufValid ? r_rdataBuf : bus.rdata;
    assign w_loadShift = w_loadSel >> {r_addrLo, 3'b000};

    // Size casts of a $signed operand sign-extend, of an unsigned one
    // zero-extend. For XLEN=32 the lw case is the whole word.
    always_comb begin
        w_loadData = w_loadShift;
        case (r_ldOp)
            3'd1:    w_loadData = XLEN'($signed(w_loadShift[7:0]));
            3'd2:    w_loadData = XLEN'(w_loadShift[7:0]);
            3'd3:    w_loadData = XLEN'($signed(w_loadShift[15:0]));
            3'd4:    w_loadData = XLEN'(w_loadShift[15:0]);
            3'd5:    w_loadData = XLEN'($signed(w_loadShift[31:0]));
            3'd6:    w_loadData = XLEN'(w_loadShift[31:0]);
            default: w_loadData = w_loadShift;
        endcase
    end

    // Stage registers, response buffer and discard counter. Flush wins over
    // everything; otherwise a new capture replaces the leaving instruction,
    // an advance empties the stage, and a response that WB cannot take yet
    // is parked. The discard counter may go up and down in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= 1'b0;
            r_req        <= 1'b0;
            r_ldOp       <= '0;
            r_addrLo     <= '0;
            r_result     <= '0;
            r_rfWe       <= 1'b0;
            r_rfWaddr    <= '0;
            r_pc         <= '0;
            r_exc        <= 1'b0;
            r_bufValid   <= 1'b0;
            r_rdataBuf   <= '0;
            r_discardCnt <= '0;
        end else begin
            if (bus.flush) begin
                r_valid    <= 1'b0;
                r_bufValid <= 1'b0;
            end else if (bus.ex_valid && w_allowIn) begin
                r_valid    <= 1'b1;
                r_req      <= bus.ex_req;
                r_ldOp     <= bus.ex_ld_op;
                r_addrLo   <= bus.ex_addr_lo;
                r_result   <= bus.ex_result;
                r_rfWe     <= bus.ex_rf_we;
                r_rfWaddr  <= bus.ex_rf_waddr;
                r_pc       <= bus.ex_pc;
                r_exc      <= bus.ex_exc;
                r_bufValid <= 1'b0;
            end else if (w_advance) begin
                r_valid    <= 1'b0;
                r_bufValid <= 1'b0;
            end else if (w_rspMine && !bus.wb_allow_in) begin
                r_bufValid <= 1'b1;
                r_rdataBuf <= bus.rdata;
            end
            r_discardCnt <= r_discardCnt + CW'(w_killWaiting) - CW'(w_dropRsp);
        end
    end

    assign bus.mem_allow_in = w_allowIn;
    assign bus.mem_valid    = w_memValid;
    assign bus.mem_result   = (r_ldOp != 3'd0) ? w_loadData : r_result;
    assign bus.mem_rf_we    = r_rfWe;
    assign bus.mem_rf_waddr = r_rfWaddr;
    assign bus.mem_pc       = r_pc;
    assign bus.mem_exc      = r_exc;
    assign bus.fwd_we       = w_memValid && r_rfWe;
    assign bus.fwd_stall    = r_valid && (r_ldOp != 3'd0) && !w_readyGo;
    assign bus.req_block    = (r_discardCnt == CW'(MAX_DISCARD));
endmodule

// File: tb/tb_mem_stage_sram_like.sv
// ----------------------------------------------------------------------------
// tb_mem_stage_sram_like
//
// Purpose: self-checking bench for mem_stage_sram_like. A 64-bit instance is
// driven by scripted and random stimulus and compared each cycle against a
// transaction-level model (one held instruction plus a queue of outstanding
// SRAM responses tagged live/orphaned). A 32-bit instance runs the scripted
// XLEN=32 scenarios against fixed expected values.
// ----------------------------------------------------------------------------
module tb_mem_stage_sram_like;
    localparam int MAXD = 3;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mem_stage_sram_like_if #(.XLEN(64)) bus64 ();
    mem_stage_sram_like_if #(.XLEN(32)) bus32 ();

    mem_stage_sram_like #(.XLEN(64), .MAX_DISCARD(MAXD)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus64.slave)
    );

    mem_stage_sram_like #(.XLEN(32), .MAX_DISCARD(MAXD)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: the instruction held by the stage, whether its
    // response has already arrived (and its data), and the in-order queue of
    // outstanding responses (1 = belongs to the live instruction, 0 = orphan).
    bit          mValid;
    bit          mReq;
    logic [2:0]  mOp;
    logic [2:0]  mAlo;
    logic [63:0] mRes;
    bit          mWe;
    logic [4:0]  mWa;
    logic [31:0] mPc;
    bit          mExc;
    bit          mHasData;
    logic [63:0] mData;
    bit          pendQ[$];

    logic [63:0] lastResult;
    bit          lastValid;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Load extraction from the rules: shift right by whole bytes, keep the
    // access width, then sign- or zero-extend to 64 bits.
    function automatic logic [63:0] extractLoad(input logic [2:0] op, input logic [2:0] alo,
                                                input logic [63:0] data);
        logic [63:0] v;
        logic [63:0] m;
        int          w;
        bit          sgn;
        v = data >> (int'(alo) * 8);
        case (op)
            3'd1:    begin w = 8;  sgn = 1'b1; end
            3'd2:    begin w = 8;  sgn = 1'b0; end
            3'd3:    begin w = 16; sgn = 1'b1; end
            3'd4:    begin w = 16; sgn = 1'b0; end
            3'd5:    begin w = 32; sgn = 1'b1; end
            3'd6:    begin w = 32; sgn = 1'b0; end
            default: begin w = 64; sgn = 1'b1; end
        endcase
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        v = v & m;
        if (sgn && v[w-1]) v = v | ~m;
        return v;
    endfunction

    // One cycle on the 64-bit instance: called at a falling edge, drives the
    // inputs, compares outputs against the model, advances the model to the
    // state after the next rising edge and returns at the following falling
    // edge. The bench's EX only presents an instruction when the stage can
    // take it, and the SRAM only answers when a response is outstanding.
    task automatic applyStimulus(input bit exV, input bit exReq, input logic [2:0] op,
                                 input logic [2:0] alo, input logic [63:0] res, input bit exc,
                                 input bit dok, input logic [63:0] rd, input bit fl, input bit wb);
        int          dead;
        bit          blk, respMine, avail, expV, expAllow, adv;
        logic [63:0] expRes;
        bit          we;
        logic [4:0]  wa;
        logic [31:0] pc;
        dead = 0;
        foreach (pendQ[i]) if (!pendQ[i]) dead++;
        if (pendQ.size() == 0) dok = 1'b0;
        blk = (dead == MAXD);
        if (exc || blk) exReq = 1'b0;
        respMine = dok && pendQ[0];
        avail    = !mReq || mHasData || respMine;
        expV     = mValid && avail;
        expAllow = !fl && (!mValid || (avail && wb));
        exV      = exV && expAllow;
        we = 1'($urandom);
        wa = 5'($urandom);
        pc = $urandom;

        bus64.ex_valid    = exV;
        bus64.ex_req      = exReq;
        bus64.ex_ld_op    = op;
        bus64.ex_addr_lo  = alo;
        bus64.ex_result   = res;
        bus64.ex_rf_we    = we;
        bus64.ex_rf_waddr = wa;
        bus64.ex_pc       = pc;
        bus64.ex_exc      = exc;
        bus64.data_ok     = dok;
        bus64.rdata       = rd;
        bus64.flush       = fl;
        bus64.wb_allow_in = wb;
        #1;

        lastValid  = bus64.mem_valid;
        lastResult = bus64.mem_result;
        checkOutput("mem_valid", 64'(bus64.mem_valid), 64'(expV));
        checkOutput("mem_allow_in", 64'(bus64.mem_allow_in), 64'(expAllow));
        checkOutput("fwd_stall", 64'(bus64.fwd_stall), 64'(mValid && (mOp != 3'd0) && !avail));
        checkOutput("fwd_we", 64'(bus64.fwd_we), 64'(expV && mWe));
        checkOutput("req_block", 64'(bus64.req_block), 64'(blk));
        if (expV) begin
            expRes = (mOp != 3'd0) ? extractLoad(mOp, mAlo, mHasData ? mData : rd) : mRes;
            checkOutput("mem_result", bus64.mem_result, expRes);
            checkOutput("mem_rf_we", 64'(bus64.mem_rf_we), 64'(mWe));
            checkOutput("mem_rf_waddr", 64'(bus64.mem_rf_waddr), 64'(mWa));
            checkOutput("mem_pc", 64'(bus64.mem_pc), 64'(mPc));
            checkOutput("mem_exc", 64'(bus64.mem_exc), 64'(mExc));
        end

        adv = expV && wb;
        if (dok) void'(pendQ.pop_front());
        if (fl) begin
            foreach (pendQ[i]) pendQ[i] = 1'b0;
            mValid   = 1'b0;
            mHasData = 1'b0;
        end else begin
            if (respMine && !adv) begin
                mHasData = 1'b1;
                mData    = rd;
            end
            if (exV) begin
                mValid   = 1'b1;
                mHasData = 1'b0;
                mReq     = exReq;
                mOp      = op;
                mAlo     = alo;
                mRes     = res;
                mWe      = we;
                mWa      = wa;
                mPc      = pc;
                mExc     = exc;
                if (exReq) pendQ.push_back(1'b1);
            end else if (adv) begin
                mValid   = 1'b0;
                mHasData = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle64(input bit dok, input logic [63:0] rd, input bit fl, input bit wb);
        applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 64'd0, 1'b0, dok, rd, fl, wb);
    endtask

    // Drive the 32-bit instance for one cycle and let outputs settle.
    task automatic drive32(input bit exV, input bit exReq, input logic [2:0] op,
                           input logic [1:0] alo, input logic [31:0] res,
                           input bit dok, input logic [31:0] rd, input bit wb);
        bus32.ex_valid    = exV;
        bus32.ex_req      = exReq;
        bus32.ex_ld_op    = op;
        bus32.ex_addr_lo  = alo;
        bus32.ex_result   = res;
        bus32.ex_rf_we    = 1'b1;
        bus32.ex_rf_waddr = 5'd7;
        bus32.ex_pc       = 32'h0000_1000;
        bus32.ex_exc      = 1'b0;
        bus32.data_ok     = dok;
        bus32.rdata       = rd;
        bus32.flush       = 1'b0;
        bus32.wb_allow_in = wb;
        #1;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] expv;
        mValid   = 1'b0;
        mReq     = 1'b0;
        mOp      = '0;
        mAlo     = '0;
        mRes     = '0;
        mWe      = 1'b0;
        mWa      = '0;
        mPc      = '0;
        mExc     = 1'b0;
        mHasData = 1'b0;
        mData    = '0;
        reset    = 1'b1;
        drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0);
        bus64.ex_valid = 1'b0; bus64.ex_req = 1'b0; bus64.ex_ld_op = '0;
        bus64.ex_addr_lo = '0; bus64.ex_result = '0; bus64.ex_rf_we = 1'b0;
        bus64.ex_rf_waddr = '0; bus64.ex_pc = '0; bus64.ex_exc = 1'b0;
        bus64.data_ok = 1'b0; bus64.rdata = '0; bus64.flush = 1'b0; bus64.wb_allow_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;

        $display("[TB] reset state");
        checkOutput("rst_allow_in", 64'(bus64.mem_allow_in), 64'd1);
        checkOutput("rst_mem_valid", 64'(bus64.mem_valid), 64'd0);
        checkOutput("rst_mem_result", bus64.mem_result, 64'd0);
        checkOutput("rst_mem_pc", 64'(bus64.mem_pc), 64'd0);
        checkOutput("rst_fwd_stall", 64'(bus64.fwd_stall), 64'd0);
        checkOutput("rst_req_block", 64'(bus64.req_block), 64'd0);
        checkOutput("rst32_allow_in", 64'(bus32.mem_allow_in), 64'd1);
        checkOutput("rst32_mem_valid", 64'(bus32.mem_valid), 64'd0);
        checkOutput("rst32_mem_rf_we", 64'(bus32.mem_rf_we), 64'd0);
        @(negedge clk);

        $display("[TB] XLEN=32 ALU op");
        drive32(1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, 1'b0, 32'd0, 1'b1);
        checkOutput("alu_allow_in", 64'(bus32.mem_allow_in), 64'd1);
        checkOutput("alu_valid_pre", 64'(bus32.mem_valid), 64'd0);
        @(negedge clk);
        drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("alu_valid", 64'(bus32.mem_valid), 64'd1);
        checkOutput("alu_result", 64'(bus32.mem_result), 64'h1234_5678);
        @(negedge clk);
        drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("alu_valid_post", 64'(bus32.mem_valid), 64'd0);
        @(negedge clk);

        $display("[TB] XLEN=32 lb/lbu at addr_lo=3");
        for (int k = 0; k < 2; k++) begin
            op   = (k == 0) ? 3'd1 : 3'd2;
            expv = (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
            drive32(1'b1, 1'b1, op, 2'd3, 32'd0, 1'b0, 32'd0, 1'b1);
            @(negedge clk);
            drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
            checkOutput("byte_wait_valid", 64'(bus32.mem_valid), 64'd0);
            checkOutput("byte_wait_stall", 64'(bus32.fwd_stall), 64'd1);
            @(negedge clk);
            drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b1, 32'h80FF_0000, 1'b1);
            checkOutput("byte_valid", 64'(bus32.mem_valid), 64'd1);
            checkOutput("byte_result", 64'(bus32.mem_result), 64'(expv));
            @(negedge clk);
            drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
            checkOutput("byte_valid_post", 64'(bus32.mem_valid), 64'd0);
            @(negedge clk);
        end

        $display("[TB] XLEN=32 lw buffered while WB stalls");
        drive32(1'b1, 1'b1, 3'd5, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        @(negedge clk);
        drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("buf_arrive_valid", 64'(bus32.mem_valid), 64'd1);
        checkOutput("buf_arrive_result", 64'(bus32.mem_result), 64'hDEAD_BEEF);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b0);
            checkOutput("buf_hold_flag", 64'(dut32.r_bufValid), 64'd1);
            checkOutput("buf_hold_valid", 64'(bus32.mem_valid), 64'd1);
            checkOutput("buf_hold_result", 64'(bus32.mem_result), 64'hDEAD_BEEF);
            checkOutput("buf_hold_stall", 64'(bus32.fwd_stall), 64'd0);
            @(negedge clk);
        end
        drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("buf_accept_valid", 64'(bus32.mem_valid), 64'd1);
        checkOutput("buf_accept_result", 64'(bus32.mem_result), 64'hDEAD_BEEF);
        @(negedge clk);
        drive32(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 32'd0, 1'b1);
        checkOutput("buf_cleared_valid", 64'(bus32.mem_valid), 64'd0);
        checkOutput("buf_cleared_flag", 64'(dut32.r_bufValid), 64'd0);

        $display("[TB] XLEN=64 lwu/lw at addr_lo=4");
        applyStimulus(1'b1, 1'b1, 3'd6, 3'd4, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        idle64(1'b1, 64'h9000_0001_1234_5678, 1'b0, 1'b1);
        checkOutput("lwu64_valid", 64'(lastValid), 64'd1);
        checkOutput("lwu64_result", lastResult, 64'h0000_0000_9000_0001);
        applyStimulus(1'b1, 1'b1, 3'd5, 3'd4, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        idle64(1'b1, 64'h9000_0001_1234_5678, 1'b0, 1'b1);
        checkOutput("lw64_result", lastResult, 64'hFFFF_FFFF_9000_0001);

        $display("[TB] flush while a load waits");
        applyStimulus(1'b1, 1'b1, 3'd7, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        idle64(1'b0, 64'd0, 1'b1, 1'b1);
        checkOutput("discard_after_flush", 64'(dut64.r_discardCnt), 64'd1);
        idle64(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        checkOutput("dropped_valid", 64'(lastValid), 64'd0);
        checkOutput("discard_drained", 64'(dut64.r_discardCnt), 64'd0);
        applyStimulus(1'b1, 1'b1, 3'd1, 3'd2, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        idle64(1'b1, 64'h0000_0000_00AB_0000, 1'b0, 1'b1);
        checkOutput("post_flush_result", lastResult, 64'hFFFF_FFFF_FFFF_FFAB);

        $display("[TB] flush coinciding with data_ok");
        applyStimulus(1'b1, 1'b1, 3'd7, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
        idle64(1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b1);
        checkOutput("coincide_discard", 64'(dut64.r_discardCnt), 64'd0);
        idle64(1'b0, 64'd0, 1'b0, 1'b1);
        checkOutput("coincide_empty", 64'(lastValid), 64'd0);

        $display("[TB] discard counter saturation");
        for (int k = 0; k < MAXD; k++) begin
            applyStimulus(1'b1, 1'b1, 3'd5, 3'd0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 1'b1);
            idle64(1'b0, 64'd0, 1'b1, 1'b1);
        end
        #1;
        checkOutput("req_block_full", 64'(bus64.req_block), 64'd1);
        for (int k = 0; k < MAXD; k++) idle64(1'b1, 64'(k), 1'b0, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 3000; n++) begin
            bit exc;
            exc = ($urandom_range(0, 7) == 0);
            applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                          3'($urandom), 3'($urandom), {$urandom, $urandom}, exc,
                          1'($urandom), {$urandom, $urandom},
                          ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
